// File: rtl/mojo_pkg.sv
// Shared Mojo board definitions: board clock, debounce timing and the
// debouncer state encoding.
package mojo_pkg;

    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 20;

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_WAIT_PRESS,
        ST_PRESSED,
        ST_WAIT_RELEASE
    } db_state_t;

    function automatic int debounce_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    localparam int STABLE_CYCLES_DEFAULT = debounce_cycles(CLK_HZ, DEBOUNCE_MS);

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for a single asynchronous input. Every stage
// resets to RESET_VAL so the output shows the idle level straight out of reset.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debounce_counter.sv
// Push-button conditioner: synchronizes the raw pin, debounces it, emits
// press/release strobes and keeps an 8-bit press count for the LED bank.
module button_debounce_counter
    import mojo_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES   = 2,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] press_count
);

    localparam int             CW        = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic           RAW_IDLE  = (ACTIVE_LOW != 0);

    logic          raw_sync;
    logic          btn_sync;
    db_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          level_nxt;
    logic          press_nxt;
    logic          release_nxt;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RAW_IDLE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (raw_sync)
    );

    // btn_sync is 1 when the button is pressed regardless of pin polarity
    assign btn_sync = (ACTIVE_LOW != 0) ? ~raw_sync : raw_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RELEASED;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            btn_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            if (press_nxt) begin
                press_count <= press_count + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            ST_RELEASED: begin
                cnt_nxt = '0;
                if (btn_sync) begin
                    state_nxt = ST_WAIT_PRESS;
                end
            end
            ST_WAIT_PRESS: begin
                if (!btn_sync) begin
                    state_nxt = ST_RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_PRESSED;
                    press_nxt = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_PRESSED: begin
                cnt_nxt = '0;
                if (!btn_sync) begin
                    state_nxt = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (btn_sync) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = ST_RELEASED;
                    release_nxt = 1'b1;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RELEASED;
                cnt_nxt   = '0;
            end
        endcase
        // The level is registered alongside the state so it lines up with the pulses
        level_nxt = (state_nxt == ST_PRESSED) || (state_nxt == ST_WAIT_RELEASE);
    end

endmodule
